// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: one shared prescaler and period counter,
// per-channel double-buffered duty registers and output polarity.
module pwm_multi_gen #(
  parameter int  CH    = 4,
  parameter int  CNT_W = 8,
  parameter int  DIV_W = 16,
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [DIV_W-1:0] prescale_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_duty,
  input  logic [CH-1:0]    invert_i,
  output logic [CH-1:0]    pwm_o,
  output logic             period_tick_o
);

  logic [DIV_W-1:0] q_q, q_d;
  logic [CNT_W-1:0] c_q, c_d;
  logic [CNT_W-1:0] pending_q [CH];
  logic [CNT_W-1:0] pending_d [CH];
  logic [CNT_W-1:0] active_q  [CH];
  logic [CNT_W-1:0] active_d  [CH];
  logic [CH-1:0]    pwm_q, pwm_d;
  logic             period_tick_q, period_tick_d;
  logic             tick;
  logic             wrap;

  always_comb begin
    tick = ena && (q_q == prescale_i);
    // >= so a period shortened below the current count wraps on the next tick
    wrap = tick && (c_q >= period_i);

    q_d = q_q;
    if (ena) begin
      q_d = tick ? '0 : q_q + DIV_W'(1);
    end

    c_d = c_q;
    if (tick) begin
      c_d = wrap ? '0 : c_q + CNT_W'(1);
    end

    // active takes the pending value from before any same-cycle write
    active_d = active_q;
    if (wrap) begin
      active_d = pending_q;
    end

    pending_d = pending_q;
    for (int i = 0; i < CH; i++) begin
      if (wr_en && (wr_ch == CH_W'(i))) begin
        pending_d[i] = wr_duty;
      end
    end

    for (int i = 0; i < CH; i++) begin
      pwm_d[i] = ena ? ((c_q < active_q[i]) ^ invert_i[i]) : invert_i[i];
    end

    period_tick_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q           <= '0;
      c_q           <= '0;
      pwm_q         <= '0;
      period_tick_q <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        pending_q[i] <= '0;
        active_q[i]  <= '0;
      end
    end else begin
      q_q           <= q_d;
      c_q           <= c_d;
      pwm_q         <= pwm_d;
      period_tick_q <= period_tick_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
    end
  end

  assign pwm_o         = pwm_q;
  assign period_tick_o = period_tick_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Bench for pwm_multi_gen: per-cycle scoreboard from a behavioural model plus
// period-level duty/spacing measurements. A 3-channel copy sees the same writes.
module tb_pwm_multi_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [15:0] prescale_i = '0;
  logic [7:0]  period_i = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [7:0]  wr_duty = '0;
  logic [3:0]  invert_i = '0;
  logic [3:0]  pwm_o;
  logic        period_tick_o;
  logic [2:0]  pwm3;
  logic        tick3;

  typedef struct packed {
    logic [3:0] pwm;
    logic       tick;
  } exp_t;

  exp_t sb_q[$];
  int   compare_cnt = 0;
  int   mismatch_cnt = 0;
  int   hi_cnt [4];
  int   tick_cnt;
  int   clks;

  int   m_q, m_c;
  int   m_pend [4];
  int   m_act  [4];

  pwm_multi_gen dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .prescale_i(prescale_i),
    .period_i(period_i), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .invert_i(invert_i), .pwm_o(pwm_o), .period_tick_o(period_tick_o)
  );

  // Writes to channel 3 land out of range for this copy and must be dropped
  pwm_multi_gen #(.CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .prescale_i(prescale_i),
    .period_i(period_i), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .invert_i(invert_i[2:0]), .pwm_o(pwm3), .period_tick_o(tick3)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_cnt++;
    if (observed !== expected) begin
      mismatch_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Behavioural model: outputs after this edge from state and inputs before it
  always @(posedge clk) begin
    exp_t e;
    bit   tk, wr;
    e = '0;
    if (!rst_n) begin
      m_q = 0;
      m_c = 0;
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 0;
        m_act[i]  = 0;
      end
    end else begin
      tk = ena && (m_q == int'(prescale_i));
      wr = tk && (m_c >= int'(period_i));
      for (int i = 0; i < 4; i++)
        e.pwm[i] = ena ? ((m_c < m_act[i]) ^ invert_i[i]) : invert_i[i];
      e.tick = wr;
      if (ena) m_q = tk ? 0 : (m_q + 1) % 65536;
      if (tk) m_c = wr ? 0 : m_c + 1;
      if (wr) for (int i = 0; i < 4; i++) m_act[i] = m_pend[i];
      if (wr_en) m_pend[wr_ch] = int'(wr_duty);
    end
    sb_q.push_back(e);
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checkOutput("pwm", 32'(pwm_o), 32'(e.pwm));
      checkOutput("tick", 32'(period_tick_o), 32'(e.tick));
      checkOutput("pwm3", 32'(pwm3), 32'(e.pwm[2:0]));
      checkOutput("tick3", 32'(tick3), 32'(e.tick));
    end
  end

  task automatic applyStimulus(input logic [1:0] ch, input logic [7:0] duty);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_duty = duty;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic countSample();
    for (int k = 0; k < 4; k++) if (pwm_o[k]) hi_cnt[k]++;
    if (period_tick_o) tick_cnt++;
  endtask

  task automatic measure(input int n);
    for (int k = 0; k < 4; k++) hi_cnt[k] = 0;
    tick_cnt = 0;
    repeat (n) begin
      @(negedge clk);
      countSample();
    end
  endtask

  task automatic runUntilTick(input int limit, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int k = 0; k < 4; k++) hi_cnt[k] = 0;
    tick_cnt = 0;
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      countSample();
      if (period_tick_o) seen = 1'b1;
    end
    if (!seen) checkOutput("tickTimeout", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset holds outputs at 0 even with every channel inverted
    invert_i = 4'b1111;
    repeat (3) @(negedge clk);
    checkOutput("resetPwm", 32'(pwm_o), 32'd0);
    checkOutput("resetTick", 32'(period_tick_o), 32'd0);
    invert_i = 4'b0000;

    $display("[TB] first period after reset");
    rst_n = 1'b1;
    ena = 1'b1;
    prescale_i = 16'd0;
    period_i = 8'd9;
    applyStimulus(2'd0, 8'd3);
    runUntilTick(50, clks);
    checkOutput("firstWrapClks", 32'(clks), 32'd9);
    checkOutput("preWrapHigh", 32'(hi_cnt[0]), 32'd0);
    measure(10);
    checkOutput("ch0High", 32'(hi_cnt[0]), 32'd3);
    checkOutput("ticksPer10", 32'(tick_cnt), 32'd1);

    $display("[TB] prescaling");
    prescale_i = 16'd4;
    period_i = 8'd3;
    applyStimulus(2'd1, 8'd2);
    runUntilTick(200, clks);
    runUntilTick(200, clks);
    measure(20);
    checkOutput("ch1HighPresc", 32'(hi_cnt[1]), 32'd10);
    checkOutput("ticksPer20", 32'(tick_cnt), 32'd1);
    runUntilTick(200, clks);
    checkOutput("prescSpacing", 32'(clks), 32'd20);

    $display("[TB] duty boundaries");
    prescale_i = 16'd0;
    period_i = 8'd9;
    invert_i = 4'b1000;
    applyStimulus(2'd0, 8'd0);
    applyStimulus(2'd1, 8'd10);
    applyStimulus(2'd2, 8'd255);
    applyStimulus(2'd3, 8'd5);
    runUntilTick(50, clks);
    runUntilTick(50, clks);
    measure(10);
    checkOutput("ch0Zero", 32'(hi_cnt[0]), 32'd0);
    checkOutput("ch1Full", 32'(hi_cnt[1]), 32'd10);
    checkOutput("ch2Over", 32'(hi_cnt[2]), 32'd10);
    checkOutput("ch3Invert", 32'(hi_cnt[3]), 32'd5);

    $display("[TB] write in the wrap cycle");
    repeat (9) @(negedge clk);
    applyStimulus(2'd2, 8'd7);
    checkOutput("wrapAligned", 32'(period_tick_o), 32'd1);
    measure(10);
    checkOutput("ch2OldDuty", 32'(hi_cnt[2]), 32'd10);
    measure(10);
    checkOutput("ch2NewDuty", 32'(hi_cnt[2]), 32'd7);

    $display("[TB] period reduced mid-period");
    period_i = 8'd200;
    runUntilTick(300, clks);
    repeat (150) @(negedge clk);
    period_i = 8'd50;
    @(negedge clk);
    checkOutput("reduceWrap", 32'(period_tick_o), 32'd1);
    runUntilTick(100, clks);
    checkOutput("reducedPeriod", 32'(clks), 32'd51);

    $display("[TB] enable gap and async reset");
    period_i = 8'd9;
    invert_i = 4'b0000;
    applyStimulus(2'd0, 8'd6);
    runUntilTick(50, clks);
    runUntilTick(50, clks);
    repeat (3) @(negedge clk);
    ena = 1'b0;
    invert_i = 4'b0101;
    repeat (37) @(negedge clk);
    checkOutput("gapIdle", 32'(pwm_o), 32'h5);
    checkOutput("gapNoTick", 32'(period_tick_o), 32'd0);
    ena = 1'b1;
    invert_i = 4'b0000;
    runUntilTick(50, clks);
    checkOutput("resumeClks", 32'(clks), 32'd7);
    checkOutput("resumeCh0High", 32'(hi_cnt[0]), 32'd3);
    checkOutput("resumeCh2High", 32'(hi_cnt[2]), 32'd4);

    invert_i = 4'b1111;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncRstPwm", 32'(pwm_o), 32'd0);
    checkOutput("asyncRstTick", 32'(period_tick_o), 32'd0);
    checkOutput("asyncRstPwm3", 32'(pwm3), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule
